// File: rtl/imem_arbiter.sv
// Shares the instruction-memory read port between fetch (F) and debug (D) requesters.
// Build option IMEM_ARB_FETCH_PRIO_EN: fixed F priority with a D starvation guard.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  f_req_valid,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    output logic                  f_req_ready,
    output logic                  f_rsp_valid,
    output logic [DATA_WIDTH-1:0] f_rsp_data,
    output logic                  f_rsp_err,
    input  logic                  f_rsp_ready,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic                  d_rsp_err,
    input  logic                  d_rsp_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic { PORT_F = 1'b0, PORT_D = 1'b1 } port_e;

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

    logic                  inflight_q, inflight_d;
    logic                  hold_q, hold_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    port_e                 rsp_port_q, rsp_port_d;
    port_e                 last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  busy, rsp_fire, slot_free, accept, win_err;
    port_e                 winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] rsp_word;

    assign busy      = inflight_q | hold_q;
    assign rsp_word  = hold_q ? hold_data_q : (err_q ? '0 : mem_rdata);
    assign rsp_fire  = busy & ((rsp_port_q == PORT_F) ? f_rsp_ready : d_rsp_ready);
    // Gated by reset_n so nothing is accepted while reset is held.
    assign slot_free = reset_n & (~busy | rsp_fire);

`ifdef IMEM_ARB_FETCH_PRIO_EN
    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (accept) begin
            if (winner == PORT_D)  starve_d = '0;
            else if (d_req_valid)  starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`endif

    always_comb begin
        winner = PORT_F;
        if (f_req_valid && d_req_valid) begin
`ifdef IMEM_ARB_FETCH_PRIO_EN
            winner = (starve_q == 4'd8) ? PORT_D : PORT_F;
`else
            winner = (last_grant_q == PORT_F) ? PORT_D : PORT_F;
`endif
        end else if (d_req_valid) begin
            winner = PORT_D;
        end
    end

    assign accept      = slot_free & (f_req_valid | d_req_valid);
    assign f_req_ready = slot_free & f_req_valid & (winner == PORT_F);
    assign d_req_ready = slot_free & d_req_valid & (winner == PORT_D);
    assign win_addr    = (winner == PORT_F) ? f_req_addr : d_req_addr;
    assign win_err     = (win_addr[1:0] != 2'b00) || ({1'b0, win_addr} >= ADDR_LIMIT);
    // The address is still presented for an erroring request; its read data is discarded.
    assign mem_addr    = accept ? win_addr : mem_addr_q;

    always_comb begin
        f_rsp_valid = 1'b0;
        f_rsp_data  = '0;
        f_rsp_err   = 1'b0;
        d_rsp_valid = 1'b0;
        d_rsp_data  = '0;
        d_rsp_err   = 1'b0;
        if (rsp_port_q == PORT_F) begin
            f_rsp_valid = busy;
            f_rsp_data  = busy ? rsp_word : '0;
            f_rsp_err   = busy & err_q;
        end else begin
            d_rsp_valid = busy;
            d_rsp_data  = busy ? rsp_word : '0;
            d_rsp_err   = busy & err_q;
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        inflight_d   = inflight_q;
        hold_d       = hold_q;
        hold_data_d  = hold_data_q;
        err_d        = err_q;
        rsp_port_d   = rsp_port_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            inflight_d   = 1'b1;
            hold_d       = 1'b0;
            err_d        = win_err;
            rsp_port_d   = winner;
            last_grant_d = winner;
        end else if (rsp_fire) begin
            inflight_d = 1'b0;
            hold_d     = 1'b0;
        end else if (inflight_q) begin
            // Consumer stalled: freeze the word before the memory output moves on.
            inflight_d  = 1'b0;
            hold_d      = 1'b1;
            hold_data_d = rsp_word;
        end
    end

    // NOTE: state registers use non-blocking assignments; all decisions are made in always_comb.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q   <= 1'b0;
            hold_q       <= 1'b0;
            hold_data_q  <= '0;
            err_q        <= 1'b0;
            rsp_port_q   <= PORT_F;
            last_grant_q <= PORT_D;
            mem_addr_q   <= '0;
        end else begin
            inflight_q   <= inflight_d;
            hold_q       <= hold_d;
            hold_data_q  <= hold_data_d;
            err_q        <= err_d;
            rsp_port_q   <= rsp_port_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: per-cycle ready vectors plus a response scoreboard.
module tb_imem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req_valid = 1'b0, d_req_valid = 1'b0;
    logic [AW-1:0] f_req_addr = '0, d_req_addr = '0;
    logic          f_rsp_ready = 1'b1, d_rsp_ready = 1'b1;
    logic          f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err;
    logic [DW-1:0] f_rsp_data, d_rsp_data, mem_rdata;
    logic [AW-1:0] mem_addr;

    imem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
        .f_rsp_ready(f_rsp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .d_rsp_ready(d_rsp_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) mem_rdata <= mem[mem_addr[11:2]];

    typedef struct { logic port; logic [DW-1:0] data; logic err; } exp_t;
    typedef struct {
        logic fv; logic [AW-1:0] fa; logic dv; logic [AW-1:0] da;
        logic exp_fr; logic exp_dr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   checks = 0;
    int   failures = 0;
    logic acc_prev = 1'b0;
    logic acc_prev_port = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic addr_err(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (a >= AW'(DEPTH * 4));
    endfunction

    function automatic exp_t make_exp(input logic p, input logic [AW-1:0] a);
        exp_t e;
        e.port = p;
        e.err  = addr_err(a);
        e.data = e.err ? '0 : mem[a[11:2]];
        return e;
    endfunction

    function automatic vec_t vec(input logic fv, input logic [AW-1:0] fa, input logic dv,
                                 input logic [AW-1:0] da, input logic efr, input logic edr);
        vec_t v;
        v.fv = fv; v.fa = fa; v.dv = dv; v.da = da; v.exp_fr = efr; v.exp_dr = edr;
        return v;
    endfunction

    task automatic pop_cmp(input logic port, input logic [DW-1:0] data, input logic err);
        exp_t e;
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(port ? "d_rsp_port" : "f_rsp_port", port, e.port);
            check(port ? "d_rsp_data" : "f_rsp_data", data, e.data);
            check(port ? "d_rsp_err" : "f_rsp_err", err, e.err);
        end
    endtask

    // Response scoreboard: responses popped before this cycle's accept is pushed.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            acc_prev = 1'b0;
        end else begin
            check("single_rsp_valid", f_rsp_valid & d_rsp_valid, 1'b0);
            check("single_grant", f_req_ready & d_req_ready, 1'b0);
            if (acc_prev)
                check("rsp_latency", acc_prev_port ? d_rsp_valid : f_rsp_valid, 1'b1);
            if (f_rsp_valid && f_rsp_ready) pop_cmp(1'b0, f_rsp_data, f_rsp_err);
            if (d_rsp_valid && d_rsp_ready) pop_cmp(1'b1, d_rsp_data, d_rsp_err);
            acc_prev = 1'b0;
            if (f_req_valid && f_req_ready) begin
                check("mem_addr_f", mem_addr, f_req_addr);
                sb.push_back(make_exp(1'b0, f_req_addr));
                acc_prev = 1'b1;
                acc_prev_port = 1'b0;
            end
            if (d_req_valid && d_req_ready) begin
                check("mem_addr_d", mem_addr, d_req_addr);
                sb.push_back(make_exp(1'b1, d_req_addr));
                acc_prev = 1'b1;
                acc_prev_port = 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [AW-1:0] fa, input logic dv, input logic [AW-1:0] da);
        f_req_valid = fv; f_req_addr = fa;
        d_req_valid = dv; d_req_addr = da;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b0, '0);
        f_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) next_cycle();
        next_cycle();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w8;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 ^ (DW'(i) * 32'h0001_0103);
        mem[4] = 32'hDEAD_BEEF;

        vecs[0]  = vec(1, 32'h10, 0, 32'h0,    1, 0);
        vecs[1]  = vec(1, 32'h0,  0, 32'h0,    1, 0);
        vecs[2]  = vec(1, 32'h4,  0, 32'h0,    1, 0);
        vecs[3]  = vec(1, 32'h8,  0, 32'h0,    1, 0);
        vecs[4]  = vec(1, 32'hC,  0, 32'h0,    1, 0);
        vecs[5]  = vec(1, 32'h0,  1, 32'h8,    0, 1);
        vecs[6]  = vec(1, 32'h0,  1, 32'hC,    1, 0);
        vecs[7]  = vec(1, 32'h4,  1, 32'hC,    0, 1);
        vecs[8]  = vec(1, 32'h4,  1, 32'h10,   1, 0);
        vecs[9]  = vec(0, 32'h0,  1, 32'h10,   0, 1);
        vecs[10] = vec(0, 32'h0,  0, 32'h0,    0, 0);
        vecs[11] = vec(0, 32'h0,  1, 32'h6,    0, 1);
        vecs[12] = vec(0, 32'h0,  1, 32'h1000, 0, 1);
        vecs[13] = vec(0, 32'h0,  1, 32'h4,    0, 1);
        vecs[14] = vec(0, 32'h0,  0, 32'h0,    0, 0);

        // Reset state, with a request already waiting.
        drive(1'b1, 32'h10, 1'b1, 32'h8);
        @(negedge clk);
        check("rst_f_req_ready", f_req_ready, 1'b0);
        check("rst_d_req_ready", d_req_ready, 1'b0);
        check("rst_f_rsp_valid", f_rsp_valid, 1'b0);
        check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("rst_f_rsp_data", f_rsp_data, '0);
        check("rst_mem_addr", mem_addr, '0);
        next_cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fv, vecs[i].fa, vecs[i].dv, vecs[i].da);
            @(negedge clk);
            check($sformatf("row%0d_f_req_ready", i), f_req_ready, vecs[i].exp_fr);
            check($sformatf("row%0d_d_req_ready", i), d_req_ready, vecs[i].exp_dr);
            next_cycle();
        end
        drain();

        // Backpressure: held F response must stay stable while the memory output changes.
        w8 = mem[8];
        f_rsp_ready = 1'b0;
        drive(1'b1, 32'h20, 1'b0, '0);
        @(negedge clk);
        check("hold_accept_f", f_req_ready, 1'b1);
        next_cycle();
        drive(1'b1, 32'h24, 1'b1, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_f_rsp_valid", c), f_rsp_valid, 1'b1);
            check($sformatf("hold%0d_f_rsp_data", c), f_rsp_data, w8);
            check($sformatf("hold%0d_f_req_ready", c), f_req_ready, 1'b0);
            check($sformatf("hold%0d_d_req_ready", c), d_req_ready, 1'b0);
            mem[8] = ~w8;
            next_cycle();
        end
        f_rsp_ready = 1'b1;
        @(negedge clk);
        check("release_f_rsp_data", f_rsp_data, w8);
        check("release_d_req_ready", d_req_ready, 1'b1);
        check("release_f_req_ready", f_req_ready, 1'b0);
        mem[8] = w8;
        next_cycle();
        d_req_valid = 1'b0;
        @(negedge clk);
        check("after_release_f_req_ready", f_req_ready, 1'b1);
        next_cycle();
        drain();

        // Reset while a response is held.
        f_rsp_ready = 1'b0;
        drive(1'b1, 32'h10, 1'b0, '0);
        @(negedge clk);
        check("pre_rst_accept", f_req_ready, 1'b1);
        next_cycle();
        f_req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("pre_rst_held_valid", f_rsp_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        drive(1'b1, 32'h4, 1'b1, 32'h8);
        #1;
        check("mid_rst_f_rsp_valid", f_rsp_valid, 1'b0);
        check("mid_rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("mid_rst_f_req_ready", f_req_ready, 1'b0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        f_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_f_wins", f_req_ready, 1'b1);
        check("post_rst_d_loses", d_req_ready, 1'b0);
        check("post_rst_no_stale_f", f_rsp_valid, 1'b0);
        check("post_rst_no_stale_d", d_rsp_valid, 1'b0);
        next_cycle();
        f_req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_d_next", d_req_ready, 1'b1);
        next_cycle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single read port of the instruction memory between two requesters: CPU instruction fetch (port F) and debug/loader read-back (port D).
- The memory has a 1-cycle registered read latency and is word-indexed by address bits [ADDR_WIDTH-1:2].
- This block arbitrates requests, drives the memory address, and routes each returned word to its requester.
- Each requester has valid/ready request and response handshakes, so response backpressure never stalls or corrupts in-flight data.

Parameters:
ADDR_WIDTH, 32, byte address width (matches instruction memory).
DATA_WIDTH, 32, instruction word width.
MEM_DEPTH, 1024, memory depth in words; addresses at or above MEM_DEPTH*4 are out of range.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
f_req_valid  input  1  fetch request valid
f_req_addr  input  ADDR_WIDTH  fetch byte address
f_req_ready  output  1  fetch request accepted this cycle when valid&ready
f_rsp_valid  output  1  fetch response valid
f_rsp_data  output  DATA_WIDTH  fetch response word
f_rsp_err  output  1  fetch response error (misaligned or out of range)
f_rsp_ready  input  1  fetch consumer ready
d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err, d_rsp_ready  same as F ports, for debug
mem_addr  output  ADDR_WIDTH  byte address to instruction memory
mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_addr is presented

Behaviour:
Reset (async assert, sync release):
- inflight_q=0, hold_q=0, last_grant_q=D (so F wins the first tie).
- All rsp_valid/rsp_err=0, all rsp_data=0, mem_addr=0, all req_ready=0.
- Reset mid-operation drops any in-flight or held response; no response is produced after release for a pre-reset request.

Response path (one slot, owner port recorded in rsp_port_q):
- rsp_valid of the owner = inflight_q | hold_q; the other port's rsp_valid=0.
- rsp_data = hold_q ? hold_data_q : (err_q ? 0 : mem_rdata); rsp_err = err_q.
- Response fires on owner rsp_valid & rsp_ready.
- If inflight_q and the response does not fire: capture the word into hold_data_q, set hold_q=1. It stays stable until fired.
- When a held response fires: hold_q=0.

Accept rule:
- slot_free = !(inflight_q|hold_q) | rsp_fire. Both req_ready=0 when !slot_free.
- When slot_free, the arbitration winner gets req_ready=1 combinationally; the loser gets 0.
- Accept: mem_addr=winner addr that cycle; inflight_q<=1, rsp_port_q<=winner, err_q<=error check.
- Latency: accept in cycle N -> rsp_valid in N+1. Sustained throughput is 1 request/cycle while the consumer holds rsp_ready=1.
- No accept and slot drained: inflight_q<=0. mem_addr holds its last value when idle.

Arbitration:
- Round-robin on simultaneous valid: grant the port not in last_grant_q.
- last_grant_q updates only on accept.
- A single valid port is granted immediately.

Error check:
- Error when addr[1:0]!=0 or addr>=MEM_DEPTH*4.
- The request is still accepted and occupies the slot; the response carries err=1, data=0.
- mem_addr is still driven, but its read data is discarded.

Handshake rules:
- Requesters hold valid/addr stable until accepted.
- req_ready never depends on the requester's own rsp_ready combinationally, except through rsp_fire of the current owner.

Optional Feature:
IMEM_ARB_FETCH_PRIO_EN:
- Defined: fixed priority, F always wins ties.
- Defined, starvation guard: an 4-bit counter of consecutive F wins while D is valid forces one D grant when it reaches 8, then clears.
- Undefined: round-robin as above; no counter.

Test Plan:
- Reset release, F requests 0x10, mem word[4]=0xDEADBEEF, f_rsp_ready=1 -> accept cycle 0, f_rsp_valid=1 with data 0xDEADBEEF cycle 1, d_rsp_valid stays 0.
- F streams 0x0,0x4,0x8,0xC back-to-back with f_rsp_ready=1 -> 4 accepts in 4 cycles; responses in order in cycles 1-4.
- F and D both valid every cycle (round-robin build) -> grants alternate F,D,F,D; each response lands on the correct port with its own word.
- F accepts 0x20, f_rsp_ready=0 for 3 cycles -> f_rsp_data holds word[8] stable while mem_rdata changes; req_ready=0 both ports; accept resumes the cycle f_rsp_ready=1.
- D requests 0x6 then 0x1000 (MEM_DEPTH=1024) -> both responses d_rsp_err=1, data 0; next D request to 0x4 returns word[1] with err=0.
- Assert reset_n=0 while held response pending -> all rsp_valid drop immediately; after release no stale response appears, and F wins the first tie.
